// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 4-byte window, STATUS bit layout and serializer states.
`timescale 1ns/1ps
package mmio_uart_tx_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_COUNT_LSB = 4;
   localparam int STAT_COUNT_MSB = 6;
   localparam int STAT_OVERFLOW  = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Circular transmit FIFO. A push into a full FIFO is only taken when a pop
// happens in the same cycle; a pop from an empty FIFO is ignored.
`timescale 1ns/1ps
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to DATA queue bytes, loads
// return STATUS/DIV one cycle later with 'hit' steering the CPU read mux.
`timescale 1ns/1ps
module mmio_uart_tx #(
   parameter logic [7:0] BASE_ADDR  = 8'hF0,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] DIV_RESET  = 8'd16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       MemRead,
   input  logic       MemWrite,
   input  logic [7:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       hit,
   output logic       tx,
   output logic       irq
);

   import mmio_uart_tx_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            sel;
   logic [1:0]      offset;
   logic            wr_access;
   logic            rd_access;
   logic            push_req;
   logic            div_wr;
   logic [7:0]      divisor;
   logic [7:0]      baud_reload;
   logic            overflow;
   logic [7:0]      status;
   logic [7:0]      read_mux;
   logic            busy;

   logic            fifo_pop;
   logic [7:0]      fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   tx_state_t       state, state_next;
   logic [7:0]      baud_cnt, baud_next;
   logic [2:0]      bit_cnt, bit_next;
   logic [7:0]      shift, shift_next;

   // A write and a read in the same cycle is treated as a write only.
   assign sel         = (address[7:2] == BASE_ADDR[7:2]);
   assign offset      = address[1:0];
   assign wr_access   = MemWrite & sel;
   assign rd_access   = MemRead & ~MemWrite & sel;
   assign push_req    = wr_access & (offset == OFF_DATA);
   assign div_wr      = wr_access & (offset == OFF_DIV);
   assign baud_reload = (divisor == 8'd0) ? 8'd0 : divisor - 8'd1;
   assign busy        = (state != ST_IDLE);
   assign irq         = fifo_empty & ~busy;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .pop   (fifo_pop),
      .wdata (data_in),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Assemble STATUS and select the register being read.
   always_comb begin
      status                                = '0;
      status[STAT_EMPTY]                    = fifo_empty;
      status[STAT_FULL]                     = fifo_full;
      status[STAT_BUSY]                     = busy;
      status[STAT_COUNT_MSB:STAT_COUNT_LSB] = 3'(fifo_count);
      status[STAT_OVERFLOW]                 = overflow;
      read_mux = '0;
      case (offset)
         OFF_STATUS: read_mux = status;
         OFF_DIV:    read_mux = divisor;
         default:    read_mux = '0;
      endcase
   end

   // Bus-side registers: divisor, sticky overflow and the registered read port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divisor  <= DIV_RESET;
         overflow <= 1'b0;
         hit      <= 1'b0;
         data_out <= '0;
      end else begin
         if (div_wr) divisor <= data_in;
         if (push_req && fifo_full && !fifo_pop)
            overflow <= 1'b1;
         else if (rd_access && offset == OFF_STATUS)
            overflow <= 1'b0;
         hit      <= rd_access;
         data_out <= rd_access ? read_mux : 8'd0;
      end
   end

   // Serializer state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
      end
   end

   // Serializer next-state and line output; the baud counter is reloaded
   // only at bit boundaries, so a new divisor applies from the next bit.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      fifo_pop   = 1'b0;
      tx         = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_rdata;
               baud_next  = baud_reload;
               state_next = ST_START;
            end
         end
         ST_START: begin
            tx = 1'b0;
            if (baud_cnt == 8'd0) begin
               state_next = ST_DATA;
               bit_next   = 3'd0;
               baud_next  = baud_reload;
            end else begin
               baud_next = baud_cnt - 8'd1;
            end
         end
         ST_DATA: begin
            tx = shift[0];
            if (baud_cnt == 8'd0) begin
               shift_next = {1'b0, shift[7:1]};
               baud_next  = baud_reload;
               if (bit_cnt == 3'd7)
                  state_next = ST_STOP;
               else
                  bit_next = bit_cnt + 3'd1;
            end else begin
               baud_next = baud_cnt - 8'd1;
            end
         end
         ST_STOP: begin
            tx = 1'b1;
            if (baud_cnt == 8'd0) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_next = fifo_rdata;
                  baud_next  = baud_reload;
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               baud_next = baud_cnt - 8'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a line-level UART receiver model
// decodes tx into bytes/gaps, and directed plus randomized steps compare
// register reads and received frames against values derived from the rules.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       MemRead = 1'b0;
   logic       MemWrite = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       hit;
   logic       tx;
   logic       irq;

   int checks = 0;
   int errors = 0;

   // Receiver model state
   int         rxDiv = 16;
   bit         rxActive = 1'b0;
   int         rxCycle = 0;
   int         idleCount = 0;
   bit         rxBad = 1'b0;
   logic [9:0] rxBits = '0;
   logic [7:0] rxBytes [$];
   bit         rxOk [$];
   int         rxGap [$];

   always #5 clock = ~clock;

   mmio_uart_tx dut (
      .clock    (clock),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .hit      (hit),
      .tx       (tx),
      .irq      (irq)
   );

   // Line receiver: a frame is 10 bit periods of rxDiv clocks, each period
   // must hold a constant level; gap counts idle-high samples between frames.
   always @(negedge clock) begin
      int bitIdx;
      if (reset !== 1'b1) begin
         rxActive  = 1'b0;
         idleCount = 0;
      end else begin
         if (!rxActive) begin
            if (tx === 1'b0) begin
               rxActive = 1'b1;
               rxCycle  = 0;
               rxBad    = 1'b0;
               rxGap.push_back(idleCount);
            end else begin
               idleCount++;
            end
         end
         if (rxActive) begin
            bitIdx = rxCycle / rxDiv;
            if (rxCycle % rxDiv == 0)
               rxBits[bitIdx] = tx;
            else if (tx !== rxBits[bitIdx])
               rxBad = 1'b1;
            rxCycle++;
            if (rxCycle == 10 * rxDiv) begin
               rxBytes.push_back(rxBits[8:1]);
               rxOk.push_back(!rxBad && rxBits[0] === 1'b0 && rxBits[9] === 1'b1);
               rxActive  = 1'b0;
               idleCount = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One bus cycle presented at a falling edge; returns on the next falling
   // edge, where a read's hit/data_out are valid.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [7:0] addr, input logic [7:0] data);
      MemRead  = rd;
      MemWrite = wr;
      address  = addr;
      data_in  = data;
      @(negedge clock);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [7:0] addr,
                            input logic expHit, input logic [7:0] expData);
      applyStimulus(1'b1, 1'b0, addr, 8'h00);
      checkOutput({tag, "_hit"}, 16'(hit), 16'(expHit));
      checkOutput({tag, "_data"}, 16'(data_out), 16'(expData));
   endtask

   task automatic clearRx();
      rxBytes.delete();
      rxOk.delete();
      rxGap.delete();
   endtask

   task automatic waitFrames(input string tag, input int n, input int budget);
      int w = 0;
      while (rxBytes.size() < n && w < budget) begin
         @(negedge clock);
         w++;
      end
      checkOutput({tag, "_frames"}, 16'(rxBytes.size()), 16'(n));
   endtask

   // Compare received frames with the expected byte list; frames after the
   // first must follow with no idle gap.
   task automatic checkFrames(input string tag, input logic [7:0] expQ [$]);
      for (int i = 0; i < expQ.size(); i++) begin
         logic [15:0] b, ok, gap;
         b   = (i < rxBytes.size()) ? 16'(rxBytes[i]) : 16'hFFFF;
         ok  = (i < rxOk.size())    ? 16'(rxOk[i])    : 16'hFFFF;
         gap = (i < rxGap.size())   ? 16'(rxGap[i])   : 16'hFFFF;
         checkOutput($sformatf("%s_byte%0d", tag, i), b, 16'(expQ[i]));
         checkOutput($sformatf("%s_fmt%0d", tag, i), ok, 16'd1);
         if (i > 0) checkOutput($sformatf("%s_gap%0d", tag, i), gap, 16'd0);
      end
   endtask

   initial begin
      logic [7:0] expQ [$];
      logic [7:0] rb;
      int d, n;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_tx", 16'(tx), 16'd1);
      checkOutput("rst_irq", 16'(irq), 16'd1);
      checkOutput("rst_hit", 16'(hit), 16'd0);
      checkOutput("rst_dout", 16'(data_out), 16'd0);
      reset = 1'b1;
      @(negedge clock);

      readCheck("status_idle", 8'hF1, 1'b1, 8'h01);
      @(negedge clock);
      checkOutput("hit_one_cycle", 16'(hit), 16'd0);
      checkOutput("dout_cleared", 16'(data_out), 16'd0);
      checkOutput("idle_tx", 16'(tx), 16'd1);
      readCheck("div_reset", 8'hF2, 1'b1, 8'd16);

      // Single frame 0xA5 at divisor 4, with write-to-start latency
      applyStimulus(1'b0, 1'b1, 8'hF2, 8'd4);
      rxDiv = 4;
      readCheck("div4", 8'hF2, 1'b1, 8'd4);
      clearRx();
      applyStimulus(1'b0, 1'b1, 8'hF0, 8'hA5);
      checkOutput("lat_tx_high", 16'(tx), 16'd1);
      checkOutput("lat_irq_low", 16'(irq), 16'd0);
      @(negedge clock);
      checkOutput("lat_tx_fall", 16'(tx), 16'd0);
      waitFrames("a5", 1, 200);
      expQ = '{8'hA5};
      checkFrames("a5", expQ);
      @(negedge clock);
      checkOutput("a5_irq_back", 16'(irq), 16'd1);
      readCheck("a5_status", 8'hF1, 1'b1, 8'h01);

      // Six back-to-back writes: one pops at once, four fill, sixth overflows
      clearRx();
      for (int i = 1; i <= 6; i++)
         applyStimulus(1'b0, 1'b1, 8'hF0, 8'(8'h11 * i));
      readCheck("ovf_status", 8'hF1, 1'b1, 8'hC6);
      readCheck("ovf_cleared", 8'hF1, 1'b1, 8'h46);
      waitFrames("burst", 5, 400);
      expQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      checkFrames("burst", expQ);
      repeat (60) @(negedge clock);
      checkOutput("burst_no_sixth", 16'(rxBytes.size()), 16'd5);
      readCheck("burst_status", 8'hF1, 1'b1, 8'h01);

      // Write into a full FIFO in the exact cycle the serializer pops it:
      // first write at edge 1, pop at edge 2, frame ends 40 clocks later.
      clearRx();
      expQ.delete();
      for (int i = 0; i < 6; i++) expQ.push_back(8'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'hF0, expQ[i]);
      repeat (36) @(negedge clock);
      applyStimulus(1'b0, 1'b1, 8'hF0, expQ[5]);
      readCheck("popfull_status", 8'hF1, 1'b1, 8'h46);
      waitFrames("popfull", 6, 500);
      checkFrames("popfull", expQ);
      @(negedge clock);

      // Randomized divisor and burst length against the receiver model
      for (int t = 0; t < 3; t++) begin
         d = $urandom_range(1, 6);
         n = $urandom_range(1, 5);
         applyStimulus(1'b0, 1'b1, 8'hF2, 8'(d));
         rxDiv = d;
         readCheck($sformatf("rnd%0d_div", t), 8'hF2, 1'b1, 8'(d));
         clearRx();
         expQ.delete();
         for (int i = 0; i < n; i++) expQ.push_back(8'($urandom));
         for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 8'hF0, expQ[i]);
         waitFrames($sformatf("rnd%0d", t), n, n * 10 * d + 50);
         checkFrames($sformatf("rnd%0d", t), expQ);
         @(negedge clock);
         readCheck($sformatf("rnd%0d_status", t), 8'hF1, 1'b1, 8'h01);
      end

      // Decode boundaries, write-wins, reserved register, divisor 0
      readCheck("unmapped", 8'h10, 1'b0, 8'h00);
      readCheck("reserved", 8'hF3, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'h10, 8'h5A);
      readCheck("unmapped_write", 8'hF1, 1'b1, 8'h01);
      applyStimulus(1'b1, 1'b1, 8'hF1, 8'h00);
      checkOutput("write_wins_hit", 16'(hit), 16'd0);
      applyStimulus(1'b0, 1'b1, 8'hF2, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'hF3, 8'hFF);
      readCheck("div_zero", 8'hF2, 1'b1, 8'h00);
      rxDiv = 1;
      clearRx();
      rb = 8'($urandom);
      expQ = '{rb};
      applyStimulus(1'b0, 1'b1, 8'hF0, rb);
      waitFrames("div0", 1, 100);
      checkFrames("div0", expQ);
      @(negedge clock);

      // Reset during DATA bit 3 (edge 18 after the write starts bit 3)
      applyStimulus(1'b0, 1'b1, 8'hF2, 8'd4);
      rxDiv = 4;
      clearRx();
      rb = 8'($urandom) & 8'hF7;
      applyStimulus(1'b0, 1'b1, 8'hF0, rb);
      repeat (18) @(negedge clock);
      checkOutput("pre_reset_bit3", 16'(tx), 16'd0);
      #1 reset = 1'b0;
      #1;
      checkOutput("midreset_tx", 16'(tx), 16'd1);
      checkOutput("midreset_irq", 16'(irq), 16'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      clearRx();
      readCheck("postreset_status", 8'hF1, 1'b1, 8'h01);
      readCheck("postreset_div", 8'hF2, 1'b1, 8'd16);
      repeat (60) @(negedge clock);
      checkOutput("postreset_quiet", 16'(rxGap.size()), 16'd0);
      checkOutput("postreset_tx", 16'(tx), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to the 8-bit processor's memory bus (MemRead/MemWrite, 8-bit address, 8-bit write data) alongside the main Memory. Processor stores to DATA queue bytes in a small FIFO. A serializer drives an 8N1 line, LSB first. Processor loads return status/divisor with the same one-cycle read latency as Memory; `hit` tells top-level read mux to select this block's data.

Parameters:
BASE_ADDR, 8'hF0, base of 4-byte register window (low 2 bits must be 0)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)
DIV_RESET, 8'd16, reset value of baud divisor (clocks per bit)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
MemRead  in  1  processor read strobe, one cycle
MemWrite  in  1  processor write strobe, one cycle
address  in  8  processor address (M1)
data_in  in  8  processor write data (B register)
data_out  out  8  registered read data
hit  out  1  registered: data_out valid for this block this cycle
tx  out  1  serial line, idle high
irq  out  1  level: FIFO empty and serializer idle

Behaviour:
- Reset (reset=0, async): FIFO empty, ptrs/count 0, FSM IDLE, tx=1, data_out=0, hit=0, divisor=DIV_RESET, overflow=0, irq=1.
- Decode: sel = address[7:2]==BASE_ADDR[7:2]. Offsets: 0 DATA (W), 1 STATUS (R), 2 DIV (R/W), 3 reserved (reads 0, writes ignored).
- Accesses with sel=0 are ignored; hit=0 next cycle.
- Read: MemRead & sel in cycle N -> hit=1 and data_out valid in cycle N+1 only; both otherwise 0/hold.
  - data_out = 0 when hit=0.
  - STATUS = {overflow, count[2:0] (zero-extended/truncated to 3 bits), busy, full, empty}, bits 7..0 mapped as [7]=overflow, [6:4]=count, [3]=0, [2]=busy, [1]=full, [0]=empty.
  - STATUS read clears overflow after sampling.
- MemRead and MemWrite both high: write wins; no read response.
- Write DATA: if not full, push data_in. If full, drop byte and set overflow (sticky).
- Write DIV: divisor <= data_in. A value of 0 is treated as 1. Takes effect at the next bit boundary.
- FIFO: circular, wraps at FIFO_DEPTH. Push and pop in the same cycle are both performed; count unchanged. Push is allowed when full only if a pop occurs in that cycle.
- FSM states IDLE, START, DATA, STOP. Bit counter 0..7; baud counter counts divisor-1 down to 0.
  - IDLE: tx=1. If FIFO is non-empty, pop into shift register, load baud counter, and go to START (tx=0 from the next cycle).
  - START: hold tx=0 for divisor clocks, then DATA with bit=0.
  - DATA: tx=shift[0] for divisor clocks; shift right; after bit 7 go to STOP.
  - STOP: tx=1 for divisor clocks. Then pop the next byte and go to START in the same cycle if FIFO is non-empty (back-to-back frames, no idle gap); else IDLE.
- busy = state != IDLE. irq = empty & ~busy.
- Frame length is exactly 10*divisor clocks.
- Latency: write DATA in cycle N with FIFO empty and IDLE -> pop in N+1, tx falls in N+2.
- Reset mid-frame: frame aborted immediately, tx=1, FIFO contents discarded.

Decomposition:
- Shared package: register offset constants (OFF_DATA, OFF_STATUS, OFF_DIV), STATUS bit positions, FSM state encoding.
- One natural sub-module: tx_fifo (parameterised depth/width, push/pop/full/empty/count).
- Serializer FSM and decode stay in mmio_uart_tx.

Test Plan:
- Reset, then read F1 -> next cycle hit=1, data_out=8'h01 (empty). tx=1, irq=1.
- Write F2=8'h04, write F0=8'hA5 -> tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. Frame=40 clocks. irq returns 1.
- Divisor 4: write 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back.
  - 1st byte pops immediately, leaving room for 4 more. 6th write overflows.
  - STATUS read = 8'hC6 (overflow, count 4, busy, full). Second STATUS read has overflow=0.
  - Exactly 5 frames emitted with no idle gap between them.
- Write F0 in the same cycle the FSM pops from a full FIFO -> byte accepted, count stays 4, overflow=0.
- Read address 8'h10 and 8'hF3 -> hit=0 / data_out=0 for 8'h10; hit=1, data_out=0 for F3. Write F2=0 -> bit period 1 clock.
- Assert reset during DATA bit 3 -> tx=1 immediately. After release, STATUS=8'h01 and no further tx activity.
